// File: rtl/energy_step_sequencer.sv
// Index sequencer: hands out PARALLELISM-wide index beats from 0 up to a latched
// target T, limits in-flight beats, and waits for all acks before signalling done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start_i && en_i
// S_RUN   | issuing beats; valid while outstanding < MAX_OUTSTANDING
// S_DRAIN | last beat accepted; waiting for outstanding acks
// S_DONE  | one-cycle done_o pulse, then back to idle
module energy_step_sequencer #(
    parameter int COUNTER_BITWIDTH = 8,
    parameter int PARALLELISM      = 4,
    parameter int MAX_OUTSTANDING  = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        start_i,
    input  logic [COUNTER_BITWIDTH-1:0] target_i,
    input  logic                        abort_i,
    output logic                        idx_valid_o,
    input  logic                        idx_ready_i,
    output logic [COUNTER_BITWIDTH-1:0] idx_o,
    output logic [PARALLELISM-1:0]      lane_mask_o,
    output logic                        idx_last_o,
    input  logic                        ack_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        protocol_err_o
);
    // One extra index bit so idx + PARALLELISM never wraps before the compare.
    localparam int              IW      = COUNTER_BITWIDTH + 1;
    localparam logic [IW-1:0]   STEP    = IW'(PARALLELISM);
    localparam logic [3:0]      MAX_OUT = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                        state, state_nxt;
    logic [IW-1:0]                 idx, idx_nxt;
    logic [COUNTER_BITWIDTH-1:0]   tgt, tgt_nxt;
    logic [3:0]                    outs, outs_nxt, outs_upd;
    logic                          valid, valid_nxt;
    logic                          err, err_nxt;
    logic                          hs, ack_ok, ack_bad, last;
    logic [IW-1:0]                 tgt_ext;
    logic [PARALLELISM-1:0]        mask;

    assign tgt_ext  = {1'b0, tgt};
    assign hs       = valid & idx_ready_i;
    assign ack_ok   = ack_i && (outs != 4'd0);
    assign ack_bad  = ack_i && (outs == 4'd0);
    assign last     = (idx + STEP) > tgt_ext;
    assign outs_upd = outs + {3'b000, hs} - {3'b000, ack_ok};

    always_comb begin
        mask = '0;
        for (int k = 0; k < PARALLELISM; k++) begin
            mask[k] = (idx + IW'(k)) <= tgt_ext;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tgt_nxt   = tgt;
        outs_nxt  = outs;
        err_nxt   = err | ack_bad;
        case (state)
            S_IDLE: begin
                if (start_i && en_i) begin
                    state_nxt = S_RUN;
                    tgt_nxt   = target_i;
                    idx_nxt   = '0;
                    outs_nxt  = '0;
                    err_nxt   = 1'b0;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_nxt = S_IDLE;
                    outs_nxt  = '0;
                end else begin
                    outs_nxt = outs_upd;
                    if (hs) begin
                        idx_nxt = idx + STEP;
                        if (last) state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_nxt = S_IDLE;
                    outs_nxt  = '0;
                end else begin
                    outs_nxt = outs_upd;
                    if (outs_upd == 4'd0) state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Registered valid: decided from next-cycle state so ready/ack never reach it combinationally.
        valid_nxt = (state_nxt == S_RUN) && (outs_nxt < MAX_OUT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            idx   <= '0;
            tgt   <= '1;
            outs  <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            tgt   <= tgt_nxt;
            outs  <= outs_nxt;
            valid <= valid_nxt;
            err   <= err_nxt;
        end
    end

    assign idx_valid_o    = valid;
    assign idx_o          = idx[COUNTER_BITWIDTH-1:0];
    assign lane_mask_o    = valid ? mask : '0;
    assign idx_last_o     = valid & last;
    assign busy_o         = (state == S_RUN) || (state == S_DRAIN);
    assign done_o         = (state == S_DONE);
    assign protocol_err_o = err;
endmodule

// File: tb/tb_energy_step_sequencer.sv
// Bench for energy_step_sequencer: directed protocol steps plus randomized runs
// checked against a beat-list / outstanding-count reference model.
module tb_energy_step_sequencer;
    localparam int CW = 8;
    localparam int P  = 4;
    localparam int MO = 2;

    logic          clk = 1'b0;
    logic          rst, en, start, abort, ready, ack;
    logic [CW-1:0] target;
    logic          valid, last, busy, done, err;
    logic [CW-1:0] idx;
    logic [P-1:0]  mask;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt;
    int last_hs_idx;

    always #5 clk = ~clk;

    energy_step_sequencer #(
        .COUNTER_BITWIDTH(CW),
        .PARALLELISM     (P),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .start_i       (start),
        .target_i      (target),
        .abort_i       (abort),
        .idx_valid_o   (valid),
        .idx_ready_i   (ready),
        .idx_o         (idx),
        .lane_mask_o   (mask),
        .idx_last_o    (last),
        .ack_i         (ack),
        .busy_o        (busy),
        .done_o        (done),
        .protocol_err_o(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Lane k is live iff base+k <= T.
    function automatic logic [31:0] exp_mask(input int base, input int t);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < P; k++) if (base + k <= t) m[k] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int t);
        en     = 1'b1;
        start  = 1'b1;
        target = CW'(t);
        step();
        start  = 1'b0;
        en     = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_busy"},  32'(busy),  0);
        chk({tag, "_done"},  32'(done),  0);
        chk({tag, "_mask"},  32'(mask),  0);
        chk({tag, "_last"},  32'(last),  0);
    endtask

    // Full run: expected beats are base = 0, P, 2P, ... <= T; the model tracks
    // accepted-but-unacked beats and expects done once all are accepted and acked.
    task automatic do_run(input int t, input int ready_pct, input int ack_pct);
        int nb, na, mo, cyc;
        bit finished, h, a;
        nb = t / P + 1;
        na = 0;
        mo = 0;
        cyc = 0;
        finished = 1'b0;
        hs_cnt = 0;
        last_hs_idx = -1;
        start_run(t);
        while (!finished && cyc < 3000) begin
            cyc++;
            chk("busy_in_run", 32'(busy), 1);
            chk("done_early", 32'(done), 0);
            if (na < nb) begin
                chk("valid_vs_outstanding", 32'(valid), 32'(mo < MO));
                if (valid === 1'b1) begin
                    chk("beat_idx",  32'(idx),  na * P);
                    chk("beat_mask", 32'(mask), exp_mask(na * P, t));
                    chk("beat_last", 32'(last), 32'(na == nb - 1));
                end
            end else begin
                chk("valid_in_drain", 32'(valid), 0);
            end
            ready = ($urandom_range(99) < ready_pct);
            ack   = (mo > 0) && ($urandom_range(99) < ack_pct);
            h = (valid === 1'b1) && ready;
            a = ack;
            if (h) begin
                hs_cnt++;
                last_hs_idx = int'(idx);
            end
            step();
            if (h) begin
                na++;
                mo++;
            end
            if (a) mo--;
            if (na == nb && mo == 0) finished = 1'b1;
        end
        ready = 1'b0;
        ack   = 1'b0;
        chk("beats_accepted", na, nb);
        chk("run_complete", 32'(finished), 1);
        if (finished) begin
            chk("done_pulse", 32'(done), 1);
            chk("busy_at_done", 32'(busy), 0);
            chk("valid_at_done", 32'(valid), 0);
            step();
            chk("done_one_cycle", 32'(done), 0);
            chk("busy_after_done", 32'(busy), 0);
            chk("err_clean_run", 32'(err), 0);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; abort = 1'b0;
        ready = 1'b0; ack = 1'b0; target = '0;
        step();
        step();
        check_idle("reset");
        chk("reset_idx", 32'(idx), 0);
        chk("reset_err", 32'(err), 0);
        rst = 1'b0;
        step();

        // start without en is ignored
        start = 1'b1; target = 8'd20;
        step();
        start = 1'b0;
        check_idle("start_no_en");

        // T=11, full-rate ready, ack one cycle after each accept
        do_run(11, 100, 100);
        // T=9: partial last beat
        do_run(9, 60, 70);
        // T=255: 64 beats, last at 252, no wrap
        do_run(255, 80, 80);
        chk("t255_beats", hs_cnt, 64);
        chk("t255_last_idx", last_hs_idx, 252);
        // T=0: single beat, single lane
        do_run(0, 50, 50);

        // backpressure and outstanding limit
        start_run(40);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(valid), 1);
            chk("stall_idx",   32'(idx),   0);
            chk("stall_mask",  32'(mask),  32'hF);
            chk("stall_last",  32'(last),  0);
            step();
        end
        ready = 1'b1;
        step();
        chk("second_beat_valid", 32'(valid), 1);
        chk("second_beat_idx",   32'(idx),   4);
        step();
        chk("full_valid_low", 32'(valid), 0);
        step();
        chk("full_valid_stays_low", 32'(valid), 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_valid_back", 32'(valid), 1);
        chk("ack_next_idx",   32'(idx),   8);
        ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort_full");

        // abort after one beat, then restart from 0
        start_run(40);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("pre_abort_busy", 32'(busy), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort_run");
        step();
        chk("abort_no_done", 32'(done), 0);
        do_run(13, 100, 100);

        // protocol error: ack in idle, sticky, cleared only by an accepted start
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("err_set", 32'(err), 1);
        step();
        chk("err_sticky", 32'(err), 1);
        start = 1'b1; target = 8'd3;
        step();
        start = 1'b0;
        chk("err_after_unqualified_start", 32'(err), 1);
        start_run(20);
        chk("err_cleared_by_start", 32'(err), 0);
        chk("run_busy", 32'(busy), 1);
        start = 1'b1; en = 1'b1; target = 8'd3;
        step();
        start = 1'b0; en = 1'b0;
        chk("busy_start_ignored_busy", 32'(busy), 1);
        chk("busy_start_ignored_idx",  32'(idx),  0);
        chk("busy_start_ignored_last", 32'(last), 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("err_ack_in_run", 32'(err), 1);
        chk("err_ack_valid_kept", 32'(valid), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("err_survives_abort", 32'(err), 1);

        // reset mid-run discards the run
        start_run(100);
        ready = 1'b1;
        step();
        step();
        ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("midrun_reset");
        chk("midrun_reset_idx", 32'(idx), 0);
        chk("midrun_reset_err", 32'(err), 0);
        step();

        for (int r = 0; r < 6; r++) begin
            do_run(int'($urandom_range(0, 255)), int'($urandom_range(30, 100)),
                   int'($urandom_range(20, 100)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/energy_step_sequencer.md
ENERGY_STEP_SEQUENCER -- requirements
Module: energy_step_sequencer

Interface
REQ-001 SHALL have parameter COUNTER_BITWIDTH, default 8, meaning width of the index and target fields.
REQ-002 SHALL have parameter PARALLELISM, default 4, meaning lanes per beat and index increment; legal range 1..2^COUNTER_BITWIDTH.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of accepted, unacknowledged beats; legal range 1..15.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port en_i, input, 1, start qualifier.
REQ-007 SHALL have port start_i, input, 1, start request.
REQ-008 SHALL have port target_i, input, COUNTER_BITWIDTH, last valid index T (unsigned).
REQ-009 SHALL have port abort_i, input, 1, cancel the current run.
REQ-010 SHALL have port idx_valid_o, output, 1, beat valid.
REQ-011 SHALL have port idx_ready_i, input, 1, downstream accepts the beat.
REQ-012 SHALL have port idx_o, output, COUNTER_BITWIDTH, base index of the beat.
REQ-013 SHALL have port lane_mask_o, output, PARALLELISM, bit k set iff idx_o+k <= T.
REQ-014 SHALL have port idx_last_o, output, 1, beat is final.
REQ-015 SHALL have port ack_i, input, 1, one beat's processing completed.
REQ-016 SHALL have ports busy_o, done_o and protocol_err_o, outputs, 1 bit each.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE->RUN SHALL occur when start_i && en_i, latching T=target_i, idx=0 and outstanding=0; start_i in any other state SHALL be ignored.
REQ-019 In RUN, idx_valid_o SHALL be 1 iff outstanding < MAX_OUTSTANDING; it SHALL be registered, with no combinational path from ack_i or idx_ready_i.
REQ-020 A handshake SHALL be idx_valid_o && idx_ready_i; on a handshake idx SHALL advance by PARALLELISM and outstanding SHALL increment.
REQ-021 While idx_valid_o=1 and idx_ready_i=0, idx_o, lane_mask_o and idx_last_o SHALL be held stable, and idx_valid_o SHALL NOT drop.
REQ-022 All index comparisons SHALL use COUNTER_BITWIDTH+1 bits; idx_last_o SHALL be 1 iff idx+PARALLELISM > T; the index SHALL never wrap.
REQ-023 A handshake on a last beat SHALL move RUN->DRAIN; idx_valid_o SHALL be 0 in DRAIN, DONE and IDLE.
REQ-024 ack_i with outstanding>0 SHALL decrement outstanding; a simultaneous handshake and ack SHALL leave outstanding unchanged.
REQ-025 ack_i with outstanding=0 SHALL be ignored for counting and SHALL set protocol_err_o, sticky until the next accepted start.
REQ-026 DRAIN->DONE SHALL occur when outstanding reaches 0, including via an ack in the same cycle as entry.
REQ-027 done_o SHALL be a one-cycle pulse in DONE, followed by DONE->IDLE.
REQ-028 busy_o SHALL be 1 in RUN and DRAIN, else 0.
REQ-029 abort_i in RUN or DRAIN SHALL force IDLE on the next cycle, clear outstanding, produce no done_o, and take priority over a handshake or ack in the same cycle.

Reset
REQ-030 rst_i=1 SHALL, at the next edge and regardless of state, force IDLE, idx=0, T=all ones, outstanding=0, idx_valid_o=0, idx_last_o=0, lane_mask_o=0, busy_o=0, done_o=0 and protocol_err_o=0; a reset mid-run SHALL discard the run.

Verification
REQ-031 T=11, P=4, ready=1, ack one cycle after each accept -> beats 0/4/8, masks 1111 each, last on 8; done_o one pulse; busy_o low after it.
REQ-032 T=9, P=4 -> beats 0/4/8; mask on 8 = 0011; idx_last_o=1 only on 8.
REQ-033 CW=8, T=255, P=4 -> exactly 64 beats, last beat idx 252 with mask 1111, no wrap to 0.
REQ-034 MAX_OUTSTANDING=2, no acks -> valid drops after 2 accepts; ready low 3 cycles mid-run -> payload stable; one ack -> valid returns next cycle.
REQ-035 abort_i during RUN after 1 beat -> IDLE next cycle, busy_o=0, no done_o; a subsequent start restarts at idx 0.
REQ-036 ack_i in IDLE -> protocol_err_o=1; it stays 1 until the next accepted start clears it; start_i while busy is ignored.
